// File: rtl/snoop_cache_if.sv
`default_nettype none
// ============================================================================
// Module   : snoop_cache_if
// Brief    : CPU request, coherence bus, snoop, fill and flush bundle of snoop_cache.
// Revision : 1.0
// ============================================================================
interface snoop_cache_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
);
  logic              execute_instruction;
  logic              instruction;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              done;
  logic              bus_req;
  logic              bus_grant;
  logic [1:0]        bus_op;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_data;
  logic              snoop_valid;
  logic [1:0]        snoop_op;
  logic [ADDR_W-1:0] snoop_addr;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_data;
  logic              flush_valid;
  logic [DATA_W-1:0] flush_data;
  logic [15:0]       hit_count;
  logic [15:0]       miss_count;

  // master is the cache itself; slave is the CPU/bus/memory environment
  modport master (
    input  execute_instruction, instruction, address, data_in, bus_grant,
           snoop_valid, snoop_op, snoop_addr, mem_valid, mem_data,
    output data_out, done, bus_req, bus_op, bus_addr, bus_data,
           flush_valid, flush_data, hit_count, miss_count
  );

  modport slave (
    output execute_instruction, instruction, address, data_in, bus_grant,
           snoop_valid, snoop_op, snoop_addr, mem_valid, mem_data,
    input  data_out, done, bus_req, bus_op, bus_addr, bus_data,
           flush_valid, flush_data, hit_count, miss_count
  );
endinterface
`default_nettype wire

// File: rtl/snoop_cache.sv
`default_nettype none
// ============================================================================
// Module   : snoop_cache
// Brief    : Direct-mapped MSI snooping cache with write-back, upgrade and fill.
//            Optional hit/miss statistics enabled by SNOOP_CACHE_STATS_EN.
// Revision : 1.0
// ============================================================================
module snoop_cache #(
  parameter int LINES  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
) (
  input  wire logic     clock,
  input  wire logic     reset_n,
  snoop_cache_if.master ctl
);
  localparam int c_IDX_W = $clog2(LINES);
  localparam int c_TAG_W = ADDR_W - c_IDX_W;

  localparam logic [1:0] c_I = 2'b00, c_S = 2'b01, c_M = 2'b10;
  localparam logic [1:0] c_OP_NONE = 2'b00, c_OP_RD = 2'b01, c_OP_WR = 2'b10, c_OP_INV = 2'b11;

  localparam logic [2:0] c_IDLE = 3'd0, c_LOOKUP = 3'd1, c_WB = 3'd2,
                         c_REQ  = 3'd3, c_FILL   = 3'd4, c_DONE = 3'd5;

  logic [2:0]         r_state, w_next_state;
  logic               r_op, r_upgrade;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata, r_rdata;
  logic [1:0]         r_lstate [LINES];
  logic [c_TAG_W-1:0] r_ltag   [LINES];
  logic [DATA_W-1:0]  r_ldata  [LINES];
  logic               r_flush_valid;
  logic [DATA_W-1:0]  r_flush_data;

  logic [c_IDX_W-1:0] w_idx, w_snp_idx;
  logic [c_TAG_W-1:0] w_tag, w_snp_tag;
  logic               w_hit, w_snp_match, w_collide, w_snp_kill, w_upg_live;

  assign w_idx       = r_addr[c_IDX_W-1:0];
  assign w_tag       = r_addr[ADDR_W-1:c_IDX_W];
  assign w_snp_idx   = ctl.snoop_addr[c_IDX_W-1:0];
  assign w_snp_tag   = ctl.snoop_addr[ADDR_W-1:c_IDX_W];
  assign w_hit       = (r_lstate[w_idx] != c_I) && (r_ltag[w_idx] == w_tag);
  assign w_snp_match = ctl.snoop_valid && (r_lstate[w_snp_idx] != c_I) && (r_ltag[w_snp_idx] == w_snp_tag);
  assign w_collide   = ctl.snoop_valid && (w_snp_idx == w_idx);
  // An invalidating snoop landing on the grant cycle must also cancel the upgrade
  assign w_snp_kill  = ctl.snoop_valid && (ctl.snoop_addr == r_addr) &&
                       ((ctl.snoop_op == c_OP_WR) || (ctl.snoop_op == c_OP_INV));
  assign w_upg_live  = r_upgrade && w_hit && (r_lstate[w_idx] == c_S) && !w_snp_kill;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= c_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:   if (ctl.execute_instruction) w_next_state = c_LOOKUP;
      c_LOOKUP: begin
        if (w_collide)                                  w_next_state = c_LOOKUP;
        else if (w_hit && r_op && r_lstate[w_idx] == c_S) w_next_state = c_REQ;
        else if (w_hit)                                 w_next_state = c_DONE;
        else if (r_lstate[w_idx] == c_M)                w_next_state = c_WB;
        else                                            w_next_state = c_REQ;
      end
      c_WB:     if (ctl.bus_grant) w_next_state = c_REQ;
      c_REQ:    if (ctl.bus_grant) w_next_state = w_upg_live ? c_DONE : c_FILL;
      c_FILL:   if (ctl.mem_valid) w_next_state = c_DONE;
      c_DONE:   w_next_state = c_IDLE;
      default:  w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    ctl.bus_req  = 1'b0;
    ctl.bus_op   = c_OP_NONE;
    ctl.bus_addr = '0;
    ctl.bus_data = '0;
    ctl.done     = 1'b0;
    ctl.data_out = '0;
    case (r_state)
      c_WB: begin
        ctl.bus_req  = 1'b1;
        ctl.bus_op   = c_OP_WR;
        ctl.bus_addr = {r_ltag[w_idx], w_idx};
        ctl.bus_data = r_ldata[w_idx];
      end
      c_REQ: begin
        ctl.bus_req  = 1'b1;
        ctl.bus_op   = w_upg_live ? c_OP_INV : (r_op ? c_OP_WR : c_OP_RD);
        ctl.bus_addr = r_addr;
      end
      c_DONE: begin
        ctl.done     = 1'b1;
        ctl.data_out = r_rdata;
      end
      default: ;
    endcase
  end

  assign ctl.flush_valid = r_flush_valid;
  assign ctl.flush_data  = r_flush_data;

  // Snoop updates are written first so controller updates in the same cycle take precedence
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op          <= 1'b0;
      r_upgrade     <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_flush_valid <= 1'b0;
      r_flush_data  <= '0;
      for (int i = 0; i < LINES; i++) begin
        r_lstate[i] <= c_I;
        r_ltag[i]   <= '0;
        r_ldata[i]  <= '0;
      end
    end else begin
      r_flush_valid <= 1'b0;
      if (w_snp_match) begin
        if (r_lstate[w_snp_idx] == c_M && ctl.snoop_op == c_OP_RD) begin
          r_flush_valid         <= 1'b1;
          r_flush_data          <= r_ldata[w_snp_idx];
          r_lstate[w_snp_idx]   <= c_S;
        end else if (r_lstate[w_snp_idx] == c_M && ctl.snoop_op == c_OP_WR) begin
          r_flush_valid         <= 1'b1;
          r_flush_data          <= r_ldata[w_snp_idx];
          r_lstate[w_snp_idx]   <= c_I;
        end else if (r_lstate[w_snp_idx] == c_S &&
                     (ctl.snoop_op == c_OP_WR || ctl.snoop_op == c_OP_INV)) begin
          r_lstate[w_snp_idx]   <= c_I;
        end
      end
      case (r_state)
        c_IDLE: if (ctl.execute_instruction) begin
          r_op      <= ctl.instruction;
          r_addr    <= ctl.address;
          r_wdata   <= ctl.data_in;
          r_upgrade <= 1'b0;
        end
        c_LOOKUP: if (!w_collide && w_hit) begin
          if (r_op && r_lstate[w_idx] == c_S) begin
            r_upgrade <= 1'b1;
          end else begin
            r_rdata <= r_op ? r_wdata : r_ldata[w_idx];
            if (r_op) r_ldata[w_idx] <= r_wdata;
          end
        end
        c_WB: if (ctl.bus_grant) r_lstate[w_idx] <= c_I;
        c_REQ: if (ctl.bus_grant) begin
          r_upgrade <= 1'b0;
          if (w_upg_live) begin
            r_lstate[w_idx] <= c_M;
            r_ldata[w_idx]  <= r_wdata;
            r_rdata         <= r_wdata;
          end
        end
        c_FILL: if (ctl.mem_valid) begin
          r_ltag[w_idx]   <= w_tag;
          r_ldata[w_idx]  <= r_op ? r_wdata : ctl.mem_data;
          r_lstate[w_idx] <= r_op ? c_M : c_S;
          r_rdata         <= r_op ? r_wdata : ctl.mem_data;
        end
        default: ;
      endcase
    end
  end

`ifdef SNOOP_CACHE_STATS_EN
  logic [15:0] r_hit_count, r_miss_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (r_state == c_LOOKUP && !w_collide) begin
      if (w_hit && r_hit_count != 16'hFFFF)        r_hit_count  <= r_hit_count + 16'd1;
      else if (!w_hit && r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
    end
  end

  assign ctl.hit_count  = r_hit_count;
  assign ctl.miss_count = r_miss_count;
`else
  assign ctl.hit_count  = 16'd0;
  assign ctl.miss_count = 16'd0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_snoop_cache.sv
`default_nettype none
// tb_snoop_cache: directed bench for snoop_cache (LINES=4, ADDR_W=5, DATA_W=4).
// Inputs change and outputs are sampled on the falling edge.
module tb_snoop_cache;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;
`ifdef SNOOP_CACHE_STATS_EN
  localparam logic [15:0] c_EXP_CNT = 16'd1;
`else
  localparam logic [15:0] c_EXP_CNT = 16'd0;
`endif

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  snoop_cache_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sif ();

  snoop_cache #(.LINES(4), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ctl     (sif.master)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic instr, input logic [4:0] addr, input logic [3:0] data);
    sif.execute_instruction = 1'b1;
    sif.instruction         = instr;
    sif.address             = addr;
    sif.data_in             = data;
    @(negedge clock);
    sif.execute_instruction = 1'b0;
  endtask

  task automatic grant_cycle();
    sif.bus_grant = 1'b1;
    @(negedge clock);
    sif.bus_grant = 1'b0;
  endtask

  task automatic fill_cycle(input logic [3:0] data);
    sif.mem_valid = 1'b1;
    sif.mem_data  = data;
    @(negedge clock);
    sif.mem_valid = 1'b0;
  endtask

  task automatic snoop_cycle(input logic [1:0] op, input logic [4:0] addr);
    sif.snoop_valid = 1'b1;
    sif.snoop_op    = op;
    sif.snoop_addr  = addr;
    @(negedge clock);
    sif.snoop_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n = 0;
    while (sif.done !== 1'b1 && n < max_cyc) begin
      @(negedge clock);
      n++;
    end
    check(tag, sif.done, 1);
  endtask

  initial begin
    reset_n                 = 1'b0;
    sif.execute_instruction = 1'b0;
    sif.instruction         = 1'b0;
    sif.address             = '0;
    sif.data_in             = '0;
    sif.bus_grant           = 1'b0;
    sif.snoop_valid         = 1'b0;
    sif.snoop_op            = 2'b00;
    sif.snoop_addr          = '0;
    sif.mem_valid           = 1'b0;
    sif.mem_data            = '0;
    repeat (2) @(negedge clock);
    check("rst_done", sif.done, 0);
    check("rst_bus_req", sif.bus_req, 0);
    check("rst_bus_op", sif.bus_op, 0);
    check("rst_data_out", sif.data_out, 0);
    check("rst_flush", sif.flush_valid, 0);
    check("rst_hit", sif.hit_count, 0);
    check("rst_miss", sif.miss_count, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Cold read miss of 06, filled with A
    accept(1'b0, 5'h06, 4'h0);
    @(negedge clock);
    check("rd06_req", sif.bus_req, 1);
    check("rd06_op", sif.bus_op, 2'b01);
    check("rd06_addr", sif.bus_addr, 5'h06);
    @(negedge clock);
    check("rd06_req_hold", sif.bus_req, 1);
    grant_cycle();
    check("rd06_req_drop", sif.bus_req, 0);
    fill_cycle(4'hA);
    check("rd06_done", sif.done, 1);
    check("rd06_data", sif.data_out, 4'hA);
    check("rd06_line_S", dut.r_lstate[2], 2'b01);
    @(negedge clock);
    check("rd06_done_pulse", sif.done, 0);

    // Read hit: done two clocks after acceptance
    accept(1'b0, 5'h06, 4'h0);
    check("hit06_early", sif.done, 0);
    @(negedge clock);
    check("hit06_done", sif.done, 1);
    check("hit06_data", sif.data_out, 4'hA);
    check("hit06_no_req", sif.bus_req, 0);
    check("stats_hit", sif.hit_count, c_EXP_CNT);
    check("stats_miss", sif.miss_count, c_EXP_CNT);
    @(negedge clock);

    // Write hit on S: invalidate, then M with data 3
    accept(1'b1, 5'h06, 4'h3);
    @(negedge clock);
    check("wr06_op_inv", sif.bus_op, 2'b11);
    check("wr06_addr", sif.bus_addr, 5'h06);
    grant_cycle();
    check("wr06_done", sif.done, 1);
    check("wr06_data", sif.data_out, 4'h3);
    check("wr06_line_M", dut.r_lstate[2], 2'b10);
    @(negedge clock);

    // Snoop read miss on M: flush 3, line to S
    snoop_cycle(2'b01, 5'h06);
    check("snrd_flush", sif.flush_valid, 1);
    check("snrd_flush_data", sif.flush_data, 4'h3);
    check("snrd_line_S", dut.r_lstate[2], 2'b01);
    @(negedge clock);
    check("snrd_flush_pulse", sif.flush_valid, 0);

    // Make line 2 Modified with 5, then read 0A: write-back then read miss
    accept(1'b1, 5'h06, 4'h5);
    @(negedge clock);
    grant_cycle();
    check("wr06b_done", sif.done, 1);
    @(negedge clock);
    accept(1'b0, 5'h0A, 4'h0);
    @(negedge clock);
    check("wb_req", sif.bus_req, 1);
    check("wb_op", sif.bus_op, 2'b10);
    check("wb_addr", sif.bus_addr, 5'h06);
    check("wb_data", sif.bus_data, 4'h5);
    grant_cycle();
    check("rd0A_op", sif.bus_op, 2'b01);
    check("rd0A_addr", sif.bus_addr, 5'h0A);
    grant_cycle();
    fill_cycle(4'h7);
    check("rd0A_data", sif.data_out, 4'h7);
    @(negedge clock);

    // Upgrade of 0A invalidated while in REQ restarts as a write miss
    accept(1'b1, 5'h0A, 4'h9);
    @(negedge clock);
    check("upg_op_inv", sif.bus_op, 2'b11);
    snoop_cycle(2'b11, 5'h0A);
    check("upg_line_I", dut.r_lstate[2], 2'b00);
    check("upg_restart_op", sif.bus_op, 2'b10);
    check("upg_restart_req", sif.bus_req, 1);
    grant_cycle();
    fill_cycle(4'hC);
    check("upg_done", sif.done, 1);
    check("upg_data", sif.data_out, 4'h9);
    check("upg_line_M", dut.r_lstate[2], 2'b10);
    @(negedge clock);

    // Snoop write miss on M: flush 9, line to I
    snoop_cycle(2'b10, 5'h0A);
    check("snwr_flush", sif.flush_valid, 1);
    check("snwr_flush_data", sif.flush_data, 4'h9);
    check("snwr_line_I", dut.r_lstate[2], 2'b00);
    @(negedge clock);

    // Load 06 again, then reset during the fill of 0E
    accept(1'b0, 5'h06, 4'h0);
    @(negedge clock);
    grant_cycle();
    fill_cycle(4'hB);
    check("rd06c_data", sif.data_out, 4'hB);
    @(negedge clock);
    accept(1'b0, 5'h0E, 4'h0);
    @(negedge clock);
    check("rd0E_req", sif.bus_req, 1);
    grant_cycle();
    sif.mem_valid = 1'b1;
    sif.mem_data  = 4'hD;
    #2 reset_n = 1'b0;
    #1;
    check("arst_bus_req", sif.bus_req, 0);
    check("arst_done", sif.done, 0);
    check("arst_hit", sif.hit_count, 0);
    check("arst_miss", sif.miss_count, 0);
    check("arst_line_I", dut.r_lstate[2], 2'b00);
    @(negedge clock);
    check("arst_fill_ignored", sif.done, 0);
    check("arst_data_out", sif.data_out, 0);
    sif.mem_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);

    // After reset, 06 must miss again
    accept(1'b0, 5'h06, 4'h0);
    @(negedge clock);
    check("post_rst_req", sif.bus_req, 1);
    check("post_rst_op", sif.bus_op, 2'b01);
    check("post_rst_addr", sif.bus_addr, 5'h06);
    grant_cycle();
    sif.mem_valid = 1'b1;
    sif.mem_data  = 4'h4;
    wait_done("post_rst_done", 5);
    sif.mem_valid = 1'b0;
    check("post_rst_data", sif.data_out, 4'h4);
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/snoop_cache.md
SNOOP_CACHE -- requirements
Module: snoop_cache

Interface
REQ-001 SHALL have parameter LINES, default 4, meaning the number of direct-mapped lines (power of two, at least 2).
REQ-002 SHALL have parameter ADDR_W, default 5, meaning the address width (greater than log2(LINES)).
REQ-003 SHALL have parameter DATA_W, default 4, meaning the data width of each line.
REQ-004 SHALL provide: clock  in  1  sole clock, rising edge.
REQ-005 SHALL provide: reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL provide: execute_instruction  in  1  request strobe, sampled only in IDLE.
REQ-007 SHALL provide: instruction  in  1  operation, 0=read, 1=write.
REQ-008 SHALL provide: address  in  ADDR_W  request address; index=address[log2(LINES)-1:0], tag=remaining bits.
REQ-009 SHALL provide: data_in  in  DATA_W  write data.
REQ-010 SHALL provide: data_out  out  DATA_W  read result.
REQ-011 SHALL provide: done  out  1  one-cycle completion pulse.
REQ-012 SHALL provide: bus_req  out  1  bus request; bus_grant  in  1  arbiter grant.
REQ-013 SHALL provide: bus_op  out  2  bus operation (00 none, 01 read miss, 10 write miss, 11 invalidate); bus_addr  out  ADDR_W  bus address; bus_data  out  DATA_W  write-back data.
REQ-014 SHALL provide: snoop_valid  in  1  snoop strobe; snoop_op  in  2  snooped operation; snoop_addr  in  ADDR_W  snooped address.
REQ-015 SHALL provide: mem_valid  in  1  fill strobe; mem_data  in  DATA_W  fill data.
REQ-016 SHALL provide: flush_valid  out  1  flush pulse; flush_data  out  DATA_W  flushed Modified data.
REQ-017 SHALL provide: hit_count  out  16  hit counter; miss_count  out  16  miss counter.

Function
REQ-018 SHALL encode each line's state in 2 bits as I=00, S=01, M=10, and store a tag and DATA_W data bits per line.
REQ-019 SHALL implement the controller states IDLE, LOOKUP, WB, REQ, FILL and DONE.
REQ-020 SHALL, in IDLE with execute_instruction=1, register instruction, address and data_in, then go to LOOKUP.
REQ-021 SHALL treat a lookup as a hit when the line state is not I and the line tag equals the request tag.
REQ-022 SHALL, on a read hit or a write hit to an M line, update the line at the LOOKUP edge (write hit: data) and pulse done one cycle later, giving a latency of 2 clocks from the accepting edge.
REQ-023 SHALL, on a write hit to an S line, issue an invalidate through REQ, then set the line to M, write the data and pulse done.
REQ-024 SHALL, on a miss with an M victim, go first to WB; WB SHALL drive bus_op=10 with the victim address and data, wait for grant, and then go to REQ.
REQ-025 SHALL, in REQ, hold bus_req=1 with bus_op/bus_addr stable until the first cycle with bus_grant=1, drop bus_req the next cycle and go to FILL.
REQ-026 SHALL, in FILL, wait indefinitely for mem_valid; on mem_valid it SHALL load tag and data, set the state to S (read) or M (write, data_in merged over the fill), and go to DONE.
REQ-027 SHALL, in DONE, pulse done=1 with data_out valid for exactly one cycle and return to IDLE.
REQ-028 SHALL process a snoop_valid whose tag matches the line in every controller state:
- read miss on M: flush_valid=1 and flush_data=line next cycle, line goes to S.
- write miss on M: flush, line goes to I.
- write miss or invalidate on S: line goes to I.
- all other cases: no change.
REQ-029 SHALL give the snoop priority when a snoop and a LOOKUP hit the same index in the same cycle; LOOKUP SHALL then repeat one cycle on the updated state.
REQ-030 SHALL restart a pending S-to-M upgrade as a write miss if its line is invalidated by a snoop while waiting in REQ.
REQ-031 SHALL ignore execute_instruction outside IDLE and ignore mem_valid outside FILL.

Reset
REQ-032 SHALL, on reset_n=0, immediately set all lines to I with tag and data 0, the controller to IDLE, every output to 0 and the counters to 0, abandoning any in-flight transaction.
REQ-033 SHALL leave reset synchronously, accepting a request on the first rising edge after reset_n goes high.

Configuration
REQ-034 SHALL, with SNOOP_CACHE_STATS_EN defined, increment hit_count on every LOOKUP hit and miss_count on every LOOKUP miss, each saturating at 16'hFFFF, and not count repeated LOOKUPs.
REQ-035 SHALL, without SNOOP_CACHE_STATS_EN, tie hit_count and miss_count to 0 and include no counter logic.

Verification
REQ-036 SHALL pass: after reset, read 5'h06 -> bus_op=01 bus_addr=06; after grant and mem_data=4'hA -> done with data_out=A, line 2 in S.
REQ-037 SHALL pass: read 5'h06 again -> done 2 clocks after acceptance with data_out=A and no bus_req.
REQ-038 SHALL pass: write 5'h06 data 4'h3 -> invalidate issued, line 2 in M; then snoop read miss 5'h06 -> flush_valid with flush_data=3, line 2 in S.
REQ-039 SHALL pass: with line 2 in M holding 5'h06, read 5'h0A -> WB with bus_addr=06, then read miss to 0A.
REQ-040 SHALL pass: reset_n pulled low during FILL -> all outputs 0 at once, and a later read of 06 misses.
REQ-041 SHALL pass: with SNOOP_CACHE_STATS_EN defined, the REQ-036..REQ-037 sequence gives hit_count=1 and miss_count=1.
